expr_string_tx: RTL and testbench
=================================

Name: expr_string_tx

Overview:
Transmitter side of the expression-string link. Serialises an arithmetic expression of single decimal digits separated by '+' or '*' into ASCII bytes, one byte per accepted transfer, for example "1+2*3". Sits upstream of the existing expression-string recogniser. Drives that recogniser's 8-bit character input, either directly or through a valid/ready stage.

Parameters:
MAX_TERMS, 8, maximum number of digit terms per expression; legal range 2..15.

Ports:
clk  input  1  system clock, rising-edge active
clr  input  1  reset; asynchronous, active-low
start  input  1  request pulse; sampled only in IDLE
num_terms  input  4  number of digit terms; legal range 1..MAX_TERMS
digits  input  4*MAX_TERMS  BCD digits; term i in bits [4i+3:4i]
ops  input  MAX_TERMS-1  operator i sits between term i and term i+1; 0='+', 1='*'
busy  output  1  high from the cycle after start is accepted until the final byte is accepted
out  output  8  ASCII character
out_valid  output  1  out holds a valid byte
out_ready  input  1  consumer accepts the byte when out_valid && out_ready at a rising edge
last  output  1  high with the final byte of the expression
err  output  1  one-cycle pulse when a start request is rejected

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE, idx=0, out=8'h00, out_valid=0, busy=0, last=0, err=0. Takes effect immediately, including mid-stream; the partial expression is dropped and never resumed.
- All outputs are registered.
- Request validation:
  - A start is legal when 1 <= num_terms <= MAX_TERMS and every used digit (terms 0..num_terms-1) is <= 9.
  - A legal start in IDLE latches num_terms, digits and ops, sets idx=0 and moves to EMIT_D.
  - An illegal start in IDLE stays in IDLE and pulses err for exactly one cycle.
  - start outside IDLE is ignored: no err pulse, and the latched data is unchanged.
- Latency: start sampled at edge k gives out_valid=1 and the first byte on out during the cycle after edge k.
- States: IDLE, EMIT_D, EMIT_O.
- EMIT_D:
  - out = 8'h30 + digit[idx], out_valid=1.
  - last=1 when idx == n-1.
  - On accept with idx == n-1: go to IDLE, out_valid=0, busy=0, last=0.
  - On accept otherwise: go to EMIT_O.
- EMIT_O:
  - out = ops[idx] ? 8'h2A : 8'h2B, out_valid=1, last=0.
  - On accept: idx = idx+1, go to EMIT_D.
- Backpressure: while out_valid && !out_ready, out, last and state hold exactly stable.
- Throughput: with out_ready tied high, one byte per cycle and no bubbles. An n-term expression takes 2n-1 cycles.
- Back-to-back: a new start is accepted only in IDLE, so there is at least one idle cycle between expressions.
- Ignored inputs: ops bits beyond index num_terms-2 are don't-care. A single-term expression emits exactly one digit byte, with last=1.
- idx is 4 bits wide and never exceeds MAX_TERMS-1, so no wrap-around.

Decomposition:
- Shared package expr_pkg holds:
  - ASCII constants CH_ZERO=8'h30, CH_PLUS=8'h2B, CH_MUL=8'h2A.
  - The tx state enum {IDLE, EMIT_D, EMIT_O}.
  - The operator encoding (0=plus, 1=mul), shared with the recogniser side.
- No sub-module; the digit-to-ASCII mapping is a single add.

Test Plan:
- Basic stream: num_terms=3, digits={3,2,1}, ops=2'b10, out_ready=1, start pulse.
  - out over 5 consecutive cycles: 0x31, 0x2B, 0x32, 0x2A, 0x33.
  - last=1 only on 0x33; busy drops the cycle after.
  - Feeding this stream into the recogniser gives out=1.
- Backpressure: same request with out_ready low for 3 cycles on the 0x2B byte.
  - out stays 0x2B with out_valid=1 throughout.
  - The remaining sequence is unchanged.
- Single term: num_terms=1, digit0=9.
  - One byte 0x39 with last=1, then IDLE.
  - No operator byte is emitted.
- Illegal requests: num_terms=0, and separately num_terms=2 with digit1=4'hA.
  - err high for exactly 1 cycle each.
  - out_valid stays 0 and busy stays 0.
- Mid-stream reset: clr=0 asynchronously while the 0x32 byte is on out.
  - out_valid, busy, last and out clear immediately.
  - After release, a fresh start emits from the first term.
- start while busy: pulse start with different data during the basic stream.
  - Original bytes are unaffected and err stays 0.

Source files
------------

// File: rtl/expr_pkg.sv
// Shared definitions for the expression-string link (transmitter and recogniser).
//   - ASCII constants for digits and operators
//   - tx FSM state encoding
//   - operator bit encoding (0 = '+', 1 = '*')
package expr_pkg;

    localparam logic [7:0] CH_ZERO = 8'h30;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_MUL  = 8'h2A;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT_D = 2'd1,
        EMIT_O = 2'd2
    } tx_state_e;

    typedef enum logic {
        OP_PLUS = 1'b0,
        OP_MUL  = 1'b1
    } op_e;

endpackage

// File: rtl/expr_string_tx.sv
// Expression-string transmitter: serialises digit terms separated by '+'/'*'
// into ASCII bytes over a valid/ready interface, one byte per accepted transfer.
// Ports:
//   clk        system clock (rising edge)
//   clr        asynchronous active-low reset
//   start      request pulse, sampled only in IDLE
//   num_terms  number of digit terms (1..MAX_TERMS)
//   digits     BCD digits, term i in [4i+3:4i]
//   ops        operator i between term i and i+1 (0='+', 1='*')
//   busy       transfer in progress
//   out        ASCII character
//   out_valid  out holds a valid byte
//   out_ready  consumer accepts the byte
//   last       final byte of the expression
//   err        one-cycle pulse on a rejected start
module expr_string_tx
    import expr_pkg::*;
#(
    parameter int unsigned MAX_TERMS = 8
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic [3:0]             num_terms,
    input  logic [4*MAX_TERMS-1:0] digits,
    input  logic [MAX_TERMS-2:0]   ops,
    output logic                   busy,
    output logic [7:0]             out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   last,
    output logic                   err
);

    tx_state_e        state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       n_q, n_d;
    // Latched data is held in 16-entry arrays so the 4-bit idx indexes them
    // directly; entries at and beyond MAX_TERMS are always zero.
    logic [15:0][3:0] dig_q, dig_d;
    logic [15:0]      ops_q, ops_d;
    logic [7:0]       out_q, out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             last_q, last_d;
    logic             err_q, err_d;

    logic [15:0][3:0] dig_in;
    logic [15:0]      ops_in;
    logic             legal;

    always_comb begin
        dig_in = '0;
        ops_in = '0;
        legal  = (num_terms != 4'd0) && (32'(num_terms) <= MAX_TERMS);
        for (int unsigned i = 0; i < MAX_TERMS; i++) begin
            dig_in[i] = digits[4*i +: 4];
            if ((i < 32'(num_terms)) && (digits[4*i +: 4] > 4'd9)) begin
                legal = 1'b0;
            end
        end
        for (int unsigned i = 0; i < MAX_TERMS - 1; i++) begin
            ops_in[i] = ops[i];
        end
    end

    // Outputs are registered, so each transition also computes the byte
    // that will be presented in the following cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        dig_d   = dig_q;
        ops_d   = ops_q;
        out_d   = out_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        last_d  = last_q;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (legal) begin
                        state_d = EMIT_D;
                        idx_d   = '0;
                        n_d     = num_terms;
                        dig_d   = dig_in;
                        ops_d   = ops_in;
                        out_d   = CH_ZERO + {4'd0, dig_in[0]};
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        last_d  = (num_terms == 4'd1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            EMIT_D: begin
                if (out_ready) begin
                    if (idx_q == n_q - 4'd1) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = EMIT_O;
                        out_d   = (ops_q[idx_q] == OP_MUL) ? CH_MUL : CH_PLUS;
                        last_d  = 1'b0;
                    end
                end
            end
            EMIT_O: begin
                if (out_ready) begin
                    state_d = EMIT_D;
                    idx_d   = idx_q + 4'd1;
                    out_d   = CH_ZERO + {4'd0, dig_q[idx_d]};
                    last_d  = (idx_d == n_q - 4'd1);
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            dig_q   <= '0;
            ops_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            dig_q   <= dig_d;
            ops_q   <= ops_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign last      = last_q;
    assign err       = err_q;

endmodule

// File: tb/tb_expr_string_tx.sv
// Directed self-checking bench for expr_string_tx (MAX_TERMS = 8).
module tb_expr_string_tx;

    localparam int unsigned MT = 8;

    logic          clk = 1'b0;
    logic          clr;
    logic          start;
    logic [3:0]    num_terms;
    logic [4*MT-1:0] digits;
    logic [MT-2:0] ops;
    logic          busy;
    logic [7:0]    out;
    logic          out_valid;
    logic          out_ready;
    logic          last;
    logic          err;

    int checks = 0;
    int errors = 0;

    expr_string_tx #(.MAX_TERMS(MT)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .num_terms (num_terms),
        .digits    (digits),
        .ops       (ops),
        .busy      (busy),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .last      (last),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the full output bundle in one go.
    task automatic chk_out(input string tag, input logic [7:0] b, input logic v,
                           input logic l, input logic bz, input logic e);
        chk({tag, ".out"},   {24'd0, out},       {24'd0, b});
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".last"},  {31'd0, last},      {31'd0, l});
        chk({tag, ".busy"},  {31'd0, busy},      {31'd0, bz});
        chk({tag, ".err"},   {31'd0, err},       {31'd0, e});
    endtask

    task automatic basic_req();
        num_terms = 4'd3;
        digits    = 32'h0000_0321;
        ops       = 7'b000_0010;
    endtask

    initial begin
        clr       = 1'b0;
        start     = 1'b0;
        num_terms = '0;
        digits    = '0;
        ops       = '0;
        out_ready = 1'b1;

        // Reset state
        #12;
        chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk) clr = 1'b1;
        @(negedge clk);
        chk_out("idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Basic stream, with a start (different data) injected mid-stream
        basic_req();
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk_out("b0", 8'h31, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("b1", 8'h2B, 1'b1, 1'b0, 1'b1, 1'b0);
        start = 1'b1; num_terms = 4'd5; digits = 32'h7777_7777; ops = '1;
        @(negedge clk);
        start = 1'b0;
        chk_out("b2", 8'h32, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("b3", 8'h2A, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("b4", 8'h33, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("bend", 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);

        // Backpressure on the '+' byte
        basic_req();
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk_out("p0", 8'h31, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("p1", 8'h2B, 1'b1, 1'b0, 1'b1, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_out("phold", 8'h2B, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk_out("p2", 8'h32, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("p3", 8'h2A, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("p4", 8'h33, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("pend", 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single term
        num_terms = 4'd1; digits = 32'hFFFF_FFF9; ops = '1;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk_out("s0", 8'h39, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("send", 8'h39, 1'b0, 1'b0, 1'b0, 1'b0);

        // Illegal: zero terms
        num_terms = 4'd0; digits = '0;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk_out("i0", 8'h39, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk_out("i0n", 8'h39, 1'b0, 1'b0, 1'b0, 1'b0);

        // Illegal: non-BCD digit in a used term
        num_terms = 4'd2; digits = 32'h0000_00A5;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk_out("i1", 8'h39, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk_out("i1n", 8'h39, 1'b0, 1'b0, 1'b0, 1'b0);

        // Too many terms for MAX_TERMS
        num_terms = 4'd9; digits = '0;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk_out("i2", 8'h39, 1'b0, 1'b0, 1'b0, 1'b1);

        // Mid-stream asynchronous reset while 0x32 is on out
        basic_req();
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_out("r2", 8'h32, 1'b1, 1'b0, 1'b1, 1'b0);
        #2 clr = 1'b0;
        #1;
        chk_out("rasync", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk) clr = 1'b1;
        @(negedge clk);
        chk_out("ridle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk_out("rf0", 8'h31, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("rf1", 8'h2B, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
